// File: rtl/tft_ctrl.sv
// tft_ctrl -- RGB565 TFT panel timing generator.
//
// Generates the hc/vc raster counters, the pixel request to an upstream line
// buffer/FIFO, and the panel-side syncs, data enable and pixel bus. Panel-side
// outputs are two clk cycles behind the counter state that produced them, so
// a pixel returned the cycle after data_req lands in the same cycle as its DE.
//
// Optional build macro: TFT_TEST_PATTERN_EN -- replaces the upstream pixel with
// an internal 8-bar colour pattern and holds data_req low.
//
// Ports:
//   clk          pixel clock (only clock)
//   rst          asynchronous active-high reset
//   vga_data     RGB565 pixel, valid the cycle after data_req
//   data_req     pixel request, high exactly in the active window
//   hcount       active-area column of the requested pixel (0 when idle)
//   vcount       active-area row of the requested pixel (0 when idle)
//   frame_start  one-cycle pulse at hc=0, vc=0
//   tft_hs/vs    syncs, active-low
//   tft_de       data enable, active-high
//   tft_rgb      RGB565 pixel to panel, 0 during blanking
//   tft_bl       backlight enable, 0 in reset
module tft_ctrl #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] vga_data,
    output logic        data_req,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        frame_start,
    output logic        tft_hs,
    output logic        tft_vs,
    output logic        tft_de,
    output logic [15:0] tft_rgb,
    output logic        tft_bl
);
    localparam logic [10:0] H_LAST  = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [10:0] V_LAST  = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_STOP  = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_STOP  = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] H_SW    = 11'(H_SYNC);
    localparam logic [10:0] V_SW    = 11'(V_SYNC);

    logic [10:0] hc, vc;
    logic [10:0] col, row;
    logic        active, raw_hs, raw_vs;
    logic        de1, hs1, vs1;

    // raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
        end else begin
            hc <= hc + 11'd1;
        end
    end

    always_comb begin
        active = !rst && (hc >= H_START) && (hc < H_STOP)
                      && (vc >= V_START) && (vc < V_STOP);
        raw_hs = (hc >= H_SW);
        raw_vs = (vc >= V_SW);
        col    = hc - H_START;
        row    = vc - V_START;
    end

`ifdef TFT_TEST_PATTERN_EN
    logic [15:0] pix1;
    logic        unused_vga;

    assign unused_vga = ^vga_data;
    assign data_req   = 1'b0;

    // bar k spans columns k*H_DISP/8 .. (k+1)*H_DISP/8-1
    function automatic logic [15:0] bar_color(input logic [10:0] c);
        logic [2:0] k;
        k = '0;
        for (int i = 1; i < 8; i++)
            if (c >= 11'(i * H_DISP / 8)) k = 3'(i);
        unique case (k)
            3'd0: bar_color = 16'hFFFF;
            3'd1: bar_color = 16'hFFE0;
            3'd2: bar_color = 16'h07FF;
            3'd3: bar_color = 16'h07E0;
            3'd4: bar_color = 16'hF81F;
            3'd5: bar_color = 16'hF800;
            3'd6: bar_color = 16'h001F;
            3'd7: bar_color = 16'h0000;
        endcase
    endfunction

    // stage-1 pixel comes from the pattern instead of the upstream buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pix1 <= '0;
        else     pix1 <= active ? bar_color(col) : 16'h0000;
    end
`else
    assign data_req = active;
`endif

    assign hcount      = data_req ? col : 11'd0;
    assign vcount      = data_req ? row : 11'd0;
    assign frame_start = !rst && (hc == 11'd0) && (vc == 11'd0);

    // stage 1: raw timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de1 <= 1'b0;
            hs1 <= 1'b1;
            vs1 <= 1'b1;
        end else begin
            de1 <= active;
            hs1 <= raw_hs;
            vs1 <= raw_vs;
        end
    end

    // stage 2: panel outputs; the pixel arrives here one cycle after the
    // request, so it lines up with the twice-registered DE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tft_de  <= 1'b0;
            tft_hs  <= 1'b1;
            tft_vs  <= 1'b1;
            tft_rgb <= 16'h0000;
        end else begin
            tft_de  <= de1;
            tft_hs  <= hs1;
            tft_vs  <= vs1;
`ifdef TFT_TEST_PATTERN_EN
            tft_rgb <= de1 ? pix1 : 16'h0000;
`else
            tft_rgb <= de1 ? vga_data : 16'h0000;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tft_bl <= 1'b0;
        else     tft_bl <= 1'b1;
    end
endmodule

// File: tb/tb_tft_ctrl.sv
// tb_tft_ctrl -- self-checking bench for tft_ctrl with a reduced raster so
// several complete frames fit in a short run. A behavioural model derives the
// raster position from the cycle count since reset and checks every output
// each cycle; directed literal checks pin the model.
module tb_tft_ctrl;
    localparam int HS = 4, HB = 2, HD = 16, HF = 3;
    localparam int VS = 2, VB = 1, VD = 5,  VF = 2;
    localparam int HT = HS + HB + HD + HF;          // 25
    localparam int VT = VS + VB + VD + VF;          // 10
    localparam int FT = HT * VT;                    // 250
    localparam int FIRST = (VS + VB) * HT + HS + HB; // 81

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] vga_data = 16'h0000;
    logic        data_req, frame_start, tft_hs, tft_vs, tft_de, tft_bl;
    logic [10:0] hcount, vcount;
    logic [15:0] tft_rgb;

    int checks = 0;
    int failures = 0;

    tft_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst(rst), .vga_data(vga_data),
        .data_req(data_req), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .tft_hs(tft_hs), .tft_vs(tft_vs),
        .tft_de(tft_de), .tft_rgb(tft_rgb), .tft_bl(tft_bl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bar(input int c);
        case (c * 8 / HD)
            0: bar = 16'hFFFF;
            1: bar = 16'hFFE0;
            2: bar = 16'h07FF;
            3: bar = 16'h07E0;
            4: bar = 16'hF81F;
            5: bar = 16'hF800;
            6: bar = 16'h001F;
            default: bar = 16'h0000;
        endcase
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [10:0] col;
    } rec_t;

    rec_t        h1 = '{1'b0, 1'b1, 1'b1, 11'd0};  // raw timing one cycle ago
    rec_t        h2 = '{1'b0, 1'b1, 1'b1, 11'd0};  // raw timing two cycles ago
    logic        r1 = 1'b1;                        // reset one cycle ago
    logic [15:0] v1 = 16'h0000;                    // vga_data one cycle ago
    int          mn = 0;                           // cycles since reset release

    always @(negedge clk) begin
        rec_t        cur;
        int          hc, vc;
        logic        act, edr;
        logic [15:0] ergb;
        cur = '{1'b0, 1'b1, 1'b1, 11'd0};
        if (rst) begin
            chk("m_req", data_req, 0);
            chk("m_hcount", hcount, 0);
            chk("m_vcount", vcount, 0);
            chk("m_fs", frame_start, 0);
            mn = 0;
        end else begin
            hc  = mn % HT;
            vc  = (mn / HT) % VT;
            act = (hc >= HS + HB) && (hc < HS + HB + HD) && (vc >= VS + VB) && (vc < VS + VB + VD);
            cur.de  = act;
            cur.hs  = (hc >= HS);
            cur.vs  = (vc >= VS);
            cur.col = act ? 11'(hc - HS - HB) : 11'd0;
`ifdef TFT_TEST_PATTERN_EN
            edr = 1'b0;
`else
            edr = act;
`endif
            chk("m_req", data_req, edr);
            chk("m_hcount", hcount, edr ? hc - HS - HB : 0);
            chk("m_vcount", vcount, edr ? vc - VS - VB : 0);
            chk("m_fs", frame_start, (mn % FT) == 0);
            mn++;
        end
        if (rst || r1) begin
            chk("m_de", tft_de, 0);
            chk("m_hs", tft_hs, 1);
            chk("m_vs", tft_vs, 1);
            chk("m_rgb", tft_rgb, 0);
        end else begin
`ifdef TFT_TEST_PATTERN_EN
            ergb = h2.de ? bar(int'(h2.col)) : 16'h0000;
`else
            ergb = h2.de ? v1 : 16'h0000;
`endif
            chk("m_de", tft_de, h2.de);
            chk("m_hs", tft_hs, h2.hs);
            chk("m_vs", tft_vs, h2.vs);
            chk("m_rgb", tft_rgb, ergb);
        end
        chk("m_bl", tft_bl, !rst && !r1);
        h2 = h1;
        h1 = cur;
        r1 = rst;
        v1 = vga_data;
    end

    // ---------------- stimulus + literal checks ----------------
    task automatic cyc(input logic r, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst = r;
        vga_data = d;
        #2;
    endtask

    initial begin
        int cnt_de, cnt_hs, cnt_vs, cnt_fs, bad;
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; bad = 0;

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 16'($urandom));
            chk("rst_hs", tft_hs, 1);
            chk("rst_vs", tft_vs, 1);
            chk("rst_de", tft_de, 0);
            chk("rst_rgb", tft_rgb, 0);
            chk("rst_bl", tft_bl, 0);
        end

        // two frames of random pixels, one directed pixel at the first request
        for (int n = 0; n < 2 * FT; n++) begin
            cyc(1'b0, (n == FIRST + 1) ? 16'h1234 : 16'($urandom));
            if (n == 0) begin
                chk("fs_first", frame_start, 1);
                chk("bl_first", tft_bl, 0);
            end
            if (n == 1) chk("bl_after", tft_bl, 1);
`ifdef TFT_TEST_PATTERN_EN
            if (n == FIRST) chk("pat_req", data_req, 0);
            if (n == FIRST + 2) chk("pat_col0", tft_rgb, 16'hFFFF);
            if (n == FIRST + 4) chk("pat_col2", tft_rgb, 16'hFFE0);
            if (n == FIRST + 2 + HD - 1) chk("pat_last", tft_rgb, 16'h0000);
`else
            if (n == FIRST - 1) chk("req_before", data_req, 0);
            if (n == FIRST) begin
                chk("req_first", data_req, 1);
                chk("hcount_first", hcount, 0);
                chk("vcount_first", vcount, 0);
            end
            if (n == FIRST + 2) begin
                chk("rgb_1234", tft_rgb, 16'h1234);
                chk("de_1234", tft_de, 1);
            end
`endif
            if (n >= 2 && n < FT + 2) begin
                cnt_de += int'(tft_de);
                cnt_hs += int'(!tft_hs);
                cnt_vs += int'(!tft_vs);
            end
            cnt_fs += int'(frame_start);
        end
        chk("de_per_frame", cnt_de, HD * VD);
        chk("hs_low_per_frame", cnt_hs, HS * VT);
        chk("vs_low_per_frame", cnt_vs, VS * HT);
        chk("fs_per_2frames", cnt_fs, 2);

        // bright input held: blanking must still be black
        for (int i = 0; i < FT; i++) begin
            cyc(1'b0, 16'hFFFF);
            if (!tft_de && tft_rgb != 16'h0000) bad++;
        end
        chk("blank_rgb_zero", bad, 0);

        // one-cycle reset at vc=6 mid-line
        for (int i = 0; i < 6 * HT + 10; i++) cyc(1'b0, 16'($urandom));
        cyc(1'b1, 16'($urandom));
        chk("mid_rst_hs", tft_hs, 1);
        chk("mid_rst_vs", tft_vs, 1);
        chk("mid_rst_de", tft_de, 0);
        chk("mid_rst_bl", tft_bl, 0);
        cyc(1'b0, 16'($urandom));
        chk("mid_fs", frame_start, 1);
        for (int i = 1; i <= FIRST; i++) begin
            cyc(1'b0, 16'($urandom));
            if (i == HS + 1) chk("mid_hs_low", tft_hs, 0);
            if (i == HS + 2) chk("mid_hs_rise", tft_hs, 1);
`ifndef TFT_TEST_PATTERN_EN
            if (i == FIRST) chk("mid_req", data_req, 1);
`endif
        end

        // random pixels with sporadic reset pulses
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 199) == 0, 16'($urandom));

        cyc(1'b0, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tft_ctrl.md
TFT_CTRL -- requirements
Module: tft_ctrl

Interface
REQ-001 SHALL have parameter H_SYNC, default 41, horizontal sync width in clk cycles.
REQ-002 SHALL have parameter H_BACK, default 2, horizontal back porch in cycles.
REQ-003 SHALL have parameter H_DISP, default 480, active pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 2, horizontal front porch in cycles.
REQ-005 SHALL have parameter V_SYNC, default 10, vertical sync width in lines.
REQ-006 SHALL have parameter V_BACK, default 2, vertical back porch in lines.
REQ-007 SHALL have parameter V_DISP, default 272, active lines per frame.
REQ-008 SHALL have parameter V_FRONT, default 2, vertical front porch in lines.
REQ-009 SHALL have port clk  input  1  pixel clock; the only clock.
REQ-010 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-011 SHALL have port vga_data  input  16  RGB565 pixel, valid the cycle after data_req.
REQ-012 SHALL have port data_req  output  1  pixel request to upstream line buffer/FIFO.
REQ-013 SHALL have port hcount  output  11  active-area column of the requested pixel.
REQ-014 SHALL have port vcount  output  11  active-area row of the requested pixel.
REQ-015 SHALL have port frame_start  output  1  one-cycle pulse at start of each frame.
REQ-016 SHALL have ports tft_hs, tft_vs  output  1 each  syncs, active-low.
REQ-017 SHALL have port tft_de  output  1  data enable, active-high.
REQ-018 SHALL have port tft_rgb  output  16  RGB565 pixel to panel.
REQ-019 SHALL have port tft_bl  output  1  backlight enable.

Function
REQ-020 hc SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* ), wrapping to 0; vc SHALL increment when hc wraps, counting 0..V_TOTAL-1, wrapping to 0.
REQ-021 Active window SHALL be hc in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) AND vc in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP); data_req SHALL be combinational from hc/vc, high exactly in the window.
REQ-022 hcount/vcount SHALL equal hc-(H_SYNC+H_BACK) / vc-(V_SYNC+V_BACK) while data_req=1, and 0 otherwise.
REQ-023 Raw syncs SHALL be low for hc<H_SYNC and vc<V_SYNC respectively.
REQ-024 Pipeline: raw de/hs/vs SHALL be registered once (stage 1), then again into tft_de/tft_hs/tft_vs (stage 2); tft_rgb SHALL be registered at stage 2 as vga_data when stage-1 de=1, else 16'h0000.
REQ-025 tft_de, tft_hs, tft_vs, tft_rgb SHALL therefore align, 2 cycles after the counter state producing them.
REQ-026 frame_start SHALL be high for the single cycle with hc=0 and vc=0.
REQ-027 tft_rgb SHALL be 0 throughout blanking regardless of vga_data.
REQ-028 tft_bl SHALL be 0 in reset and 1 from the first clk edge after reset release.

Reset
REQ-029 While rst=1: hc=vc=0, all pipeline registers cleared; tft_hs=tft_vs=1, tft_de=0, tft_rgb=0, tft_bl=0; data_req=0, hcount=vcount=0, frame_start=0 (outputs gated by rst).
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release timing SHALL restart at hc=vc=0 with frame_start on the first cycle.

Configuration
REQ-031 Macro TFT_TEST_PATTERN_EN defined: data_req SHALL be held 0, vga_data ignored, and stage-1 pixel SHALL be an 8-bar pattern by column (bar k covers k*H_DISP/8 .. (k+1)*H_DISP/8-1): FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; same latency and blanking rules apply.
REQ-032 Macro undefined: tft_rgb SHALL be sourced from vga_data per REQ-024, no pattern logic present.

Verification
REQ-033 Reset held 10 cycles then released -> tft_hs=tft_vs=1, tft_de=0, tft_rgb=0 during reset; frame_start=1 first cycle after release; tft_bl=1 thereafter.
REQ-034 Free-run defaults one frame -> line period 525 cycles, tft_hs low 41 cycles, tft_de high 480 cycles/line on 272 of 286 lines, tft_vs low 10 lines.
REQ-035 First data_req of frame at hc=43, vc=12 with hcount=0, vcount=0; vga_data=16'h1234 next cycle -> tft_rgb=16'h1234 with tft_de=1, 2 cycles after that data_req.
REQ-036 vga_data held 16'hFFFF continuously -> tft_rgb=0 whenever tft_de=0.
REQ-037 rst pulsed for 1 cycle at vc=100 -> all outputs at reset values, next frame_start on the first cycle after release, next line timing exact.
REQ-038 TFT_TEST_PATTERN_EN defined -> data_req always 0; active columns 0..59 = FFFF, 60..119 = FFE0, 420..479 = 0000.
